// File: rtl/enemy_hit_ctrl.sv
// enemy_hit_ctrl
//   Enemy hit detection and life-cycle controller, clocked once per video frame.
//   Watches the player bullet against the enemy hit box, accepts at most one
//   hit per shot, and steps the enemy through ALIVE/FLASH/DYING/DEAD/respawn.
//   It also keeps a saturating score total for the HUD.
//
// Ports
//   frame_clk      in   1   frame clock, one rising edge per frame
//   Reset          in   1   asynchronous, active-high reset
//   BallX, BallY   in  10   bullet centre (unsigned pixels)
//   bfiring        in   1   bullet in flight (0 = parked)
//   EnemyX, EnemyY in  10   enemy centre (unsigned pixels)
//   hit            out  1   one-frame pulse, a hit was accepted on the last edge
//   kill           out  1   one-frame pulse, that hit took hp to 0
//   enemy_state    out  2   0 ALIVE, 1 FLASH, 2 DYING, 3 DEAD
//   enemy_visible  out  1   sprite enable (blinks during FLASH, off when DEAD)
//   hp             out  3   remaining hit points
//   score          out 16   running score, saturates at 16'hFFFF
module enemy_hit_ctrl #(
  parameter logic [9:0]  ENEMY_HW       = 10'd8,
  parameter logic [9:0]  ENEMY_HH       = 10'd16,
  parameter logic [9:0]  BALL_SIZE      = 10'd2,
  parameter logic [2:0]  MAX_HP         = 3'd3,
  parameter logic [7:0]  FLASH_FRAMES   = 8'd4,
  parameter logic [7:0]  DYING_FRAMES   = 8'd16,
  parameter logic [7:0]  RESPAWN_FRAMES = 8'd60,
  parameter logic [15:0] SCORE_VALUE    = 16'd100
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic        bfiring,
  input  logic [9:0]  EnemyX,
  input  logic [9:0]  EnemyY,
  output logic        hit,
  output logic        kill,
  output logic [1:0]  enemy_state,
  output logic        enemy_visible,
  output logic [2:0]  hp,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    FLASH = 2'd1,
    DYING = 2'd2,
    DEAD  = 2'd3
  } state_t;

  // Box limits widened to 11 bits so the parameter sums cannot overflow.
  localparam logic [10:0] LIM_X = {1'b0, ENEMY_HW} + {1'b0, BALL_SIZE};
  localparam logic [10:0] LIM_Y = {1'b0, ENEMY_HH} + {1'b0, BALL_SIZE};

  localparam logic [7:0] FLASH_LAST = FLASH_FRAMES   - 8'd1;
  localparam logic [7:0] DYING_LAST = DYING_FRAMES   - 8'd1;
  localparam logic [7:0] DEAD_LAST  = RESPAWN_FRAMES - 8'd1;

  state_t      r_state;
  logic [7:0]  r_frame_cnt;
  logic        r_shot_used;
  logic [2:0]  r_hp;
  logic        r_hit;
  logic        r_kill;
  logic        r_visible;
  logic [15:0] r_score;

  state_t      w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_shot_nxt;
  logic [2:0]  w_hp_nxt;
  logic        w_hit_nxt;
  logic        w_kill_nxt;
  logic        w_visible_nxt;
  logic [15:0] w_score_nxt;

  // Overlap test on 11-bit signed deltas: both coordinates are zero-extended
  // first, so a bullet just left of an enemy at x=5 gives dx=-5, not a wrap.
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic        [10:0] w_adx;
  logic        [10:0] w_ady;
  logic               w_overlap;
  logic               w_hit_cond;
  logic        [16:0] w_score_sum;
  logic        [15:0] w_score_sat;

  assign w_dx  = $signed({1'b0, BallX}) - $signed({1'b0, EnemyX});
  assign w_dy  = $signed({1'b0, BallY}) - $signed({1'b0, EnemyY});
  assign w_adx = w_dx[10] ? 11'(-w_dx) : 11'(w_dx);
  assign w_ady = w_dy[10] ? 11'(-w_dy) : 11'(w_dy);

  assign w_overlap  = (w_adx <= LIM_X) && (w_ady <= LIM_Y);
  assign w_hit_cond = bfiring && w_overlap && !r_shot_used && (r_state == ALIVE);

  assign w_score_sum = {1'b0, r_score} + {1'b0, SCORE_VALUE};
  assign w_score_sat = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

  // Next-state / next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_frame_cnt;
    w_hp_nxt    = r_hp;
    w_hit_nxt   = 1'b0;
    w_kill_nxt  = 1'b0;
    w_score_nxt = r_score;

    case (r_state)
      ALIVE: begin
        if (w_hit_cond) begin
          w_hp_nxt  = r_hp - 3'd1;
          w_hit_nxt = 1'b1;
          w_cnt_nxt = 8'd0;
          // ALIVE guarantees hp >= 1, so hp == 1 is exactly the fatal hit.
          if (r_hp == 3'd1) begin
            w_state_nxt = DYING;
            w_kill_nxt  = 1'b1;
            w_score_nxt = w_score_sat;
          end else begin
            w_state_nxt = FLASH;
          end
        end
      end
      FLASH: begin
        if (r_frame_cnt == FLASH_LAST) begin
          w_state_nxt = ALIVE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_frame_cnt + 8'd1;
        end
      end
      DYING: begin
        if (r_frame_cnt == DYING_LAST) begin
          w_state_nxt = DEAD;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_frame_cnt + 8'd1;
        end
      end
      DEAD: begin
        if (r_frame_cnt == DEAD_LAST) begin
          w_state_nxt = ALIVE;
          w_hp_nxt    = MAX_HP;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_frame_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ALIVE;
        w_cnt_nxt   = 8'd0;
      end
    endcase

    // Dropping the bullet re-arms the shot; that clear beats a same-edge set.
    // Outside ALIVE hit_cond is 0, so collisions there leave the flag alone.
    if (!bfiring)
      w_shot_nxt = 1'b0;
    else if (w_hit_cond)
      w_shot_nxt = 1'b1;
    else
      w_shot_nxt = r_shot_used;

    // Visibility is derived from the values being registered, so it always
    // lines up with enemy_state in the same frame.
    case (w_state_nxt)
      DEAD:    w_visible_nxt = 1'b0;
      FLASH:   w_visible_nxt = ~w_cnt_nxt[0];
      default: w_visible_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ALIVE;
      r_frame_cnt <= 8'd0;
      r_shot_used <= 1'b0;
      r_hp        <= MAX_HP;
      r_hit       <= 1'b0;
      r_kill      <= 1'b0;
      r_visible   <= 1'b1;
      r_score     <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_cnt_nxt;
      r_shot_used <= w_shot_nxt;
      r_hp        <= w_hp_nxt;
      r_hit       <= w_hit_nxt;
      r_kill      <= w_kill_nxt;
      r_visible   <= w_visible_nxt;
      r_score     <= w_score_nxt;
    end
  end

  assign hit           = r_hit;
  assign kill          = r_kill;
  assign enemy_state   = r_state;
  assign enemy_visible = r_visible;
  assign hp            = r_hp;
  assign score         = r_score;

endmodule
